// File: rtl/gomoku_input_pkg.sv
// Shared definitions for the gomoku button-input path: repeat FSM state
// encoding and counter sizing helpers.
package gomoku_input_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to hold values 0..n; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One button channel: 2-flop synchroniser, tick-qualified stability
// counter, registered press/release pulses and the auto-repeat FSM.
module key_debounce_channel
    import gomoku_input_pkg::*;
#(
    parameter int STABLE_TICKS  = 4,
    parameter int REPEAT_DELAY  = 25,
    parameter int REPEAT_PERIOD = 8,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    input  logic en_repeat,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int SW = cnt_width(STABLE_TICKS);
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    // Counters compare against the value *before* increment, so the
    // terminal count is the target minus one.
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST  = RW'(REPEAT_PERIOD - 1);

    logic          s1, s2;
    logic [SW-1:0] stab_cnt, stab_nxt;
    logic          rise, fall;
    rpt_state_e    state, state_nxt;
    logic [RW-1:0] rpt_cnt, rpt_nxt;
    logic          rpt_fire;

    // Synchroniser; polarity is normalised before the first flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw ^ ACTIVE_LOW;
            s2 <= s1;
        end
    end

    // Stability counter: count ticks where s2 disagrees with level.
    always_comb begin
        stab_nxt = stab_cnt;
        rise     = 1'b0;
        fall     = 1'b0;
        if (tick) begin
            if (s2 == level) begin
                stab_nxt = '0;
            end else if (stab_cnt == STAB_LAST) begin
                stab_nxt = '0;
                rise     = ~level;
                fall     = level;
            end else begin
                stab_nxt = stab_cnt + 1'b1;
            end
        end
    end

    // Repeat FSM next state; a level fall overrides any repeat expiry.
    always_comb begin
        state_nxt = state;
        rpt_nxt   = rpt_cnt;
        rpt_fire  = 1'b0;
        case (state)
            RPT_IDLE: begin
                if (rise) begin
                    state_nxt = RPT_DELAY;
                    rpt_nxt   = '0;
                end
            end
            RPT_DELAY: begin
                if (tick) begin
                    if (!en_repeat) begin
                        rpt_nxt = '0;
                    end else if (rpt_cnt == DLY_LAST) begin
                        rpt_fire  = 1'b1;
                        state_nxt = RPT_REPEAT;
                        rpt_nxt   = '0;
                    end else begin
                        rpt_nxt = rpt_cnt + 1'b1;
                    end
                end
            end
            RPT_REPEAT: begin
                if (tick) begin
                    if (!en_repeat) begin
                        state_nxt = RPT_DELAY;
                        rpt_nxt   = '0;
                    end else if (rpt_cnt == PER_LAST) begin
                        rpt_fire = 1'b1;
                        rpt_nxt  = '0;
                    end else begin
                        rpt_nxt = rpt_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RPT_IDLE;
                rpt_nxt   = '0;
            end
        endcase
        if (fall) begin
            state_nxt = RPT_IDLE;
            rpt_nxt   = '0;
            rpt_fire  = 1'b0;
        end
    end

    // State registers; pulses land on the same edge as the level change.
    always_ff @(posedge clk) begin
        if (rst) begin
            stab_cnt      <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            state         <= RPT_IDLE;
            rpt_cnt       <= '0;
        end else begin
            stab_cnt      <= stab_nxt;
            level         <= level ^ (rise | fall);
            press_pulse   <= rise | rpt_fire;
            release_pulse <= fall;
            state         <= state_nxt;
            rpt_cnt       <= rpt_nxt;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel button debouncer: shared sample prescaler plus one
// independent debounce/auto-repeat channel per button.
module key_debouncer
    import gomoku_input_pkg::*;
#(
    parameter int CHANNELS      = 5,
    parameter int TICK_DIV      = 50000,
    parameter int STABLE_TICKS  = 4,
    parameter int REPEAT_DELAY  = 25,
    parameter int REPEAT_PERIOD = 8,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] en_repeat,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                sample_tick
);

    localparam int            PW       = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_cnt, pre_nxt;

    // Prescaler wraps at TICK_DIV-1.
    always_comb begin
        pre_nxt = (pre_cnt == DIV_LAST) ? '0 : pre_cnt + 1'b1;
    end

    // The strobe is registered from the next count so it is clean out of
    // reset and stays high continuously when TICK_DIV is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            pre_cnt     <= pre_nxt;
            sample_tick <= (pre_nxt == DIV_LAST);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        key_debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick         (sample_tick),
            .raw          (in[g]),
            .en_repeat    (en_repeat[g]),
            .level        (level[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench: two debouncers (tick every cycle / active-high, and divide-by-4 /
// active-low) share one stimulus; a reference model feeds a scoreboard
// queue per DUT, and directed timing checks cover the key scenarios.
module tb_key_debouncer;

    localparam int CH = 5;
    localparam int ST = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] pr;
        logic [CH-1:0] rl;
        logic          tk;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] in = '0;
    logic [CH-1:0] en_repeat = '0;
    logic [CH-1:0] lvl_a, pr_a, rl_a, lvl_b, pr_b, rl_b;
    logic          tk_a, tk_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_debouncer #(.CHANNELS(CH), .TICK_DIV(1), .STABLE_TICKS(ST),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in(in), .en_repeat(en_repeat),
        .level(lvl_a), .press_pulse(pr_a), .release_pulse(rl_a), .sample_tick(tk_a));

    key_debouncer #(.CHANNELS(CH), .TICK_DIV(4), .STABLE_TICKS(ST),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in(in), .en_repeat(en_repeat),
        .level(lvl_b), .press_pulse(pr_b), .release_pulse(rl_b), .sample_tick(tk_b));

    // ---------------- reference model ----------------
    int m_n[2];
    bit m_tk[2];
    bit m_s1[2][CH];
    bit m_s2[2][CH];
    bit m_lvl[2][CH];
    int m_run[2][CH];
    int m_ph[2][CH];   // 0 not held, 1 waiting for first repeat, 2 repeating
    int m_rc[2][CH];   // enabled ticks counted toward the next repeat

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic model_step(input int d, input int div, input bit al, output exp_t e);
        bit tk_old, sy, rose, fell, fire;
        e = '0;
        if (rst) begin
            m_n[d]  = 0;
            m_tk[d] = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_s1[d][c] = 1'b0; m_s2[d][c] = 1'b0; m_lvl[d][c] = 1'b0;
                m_run[d][c] = 0; m_ph[d][c] = 0; m_rc[d][c] = 0;
            end
        end else begin
            tk_old  = m_tk[d];
            m_n[d]  = m_n[d] + 1;
            m_tk[d] = ((m_n[d] % div) == div - 1);
            e.tk    = m_tk[d];
            for (int c = 0; c < CH; c++) begin
                sy = m_s2[d][c];
                m_s2[d][c] = m_s1[d][c];
                m_s1[d][c] = in[c] ^ al;
                rose = 1'b0; fell = 1'b0; fire = 1'b0;
                if (tk_old) begin
                    if (sy == m_lvl[d][c]) m_run[d][c] = 0;
                    else begin
                        m_run[d][c]++;
                        if (m_run[d][c] == ST) begin
                            m_run[d][c] = 0;
                            m_lvl[d][c] = ~m_lvl[d][c];
                            rose = m_lvl[d][c];
                            fell = ~m_lvl[d][c];
                        end
                    end
                end
                if (fell) begin
                    m_ph[d][c] = 0; m_rc[d][c] = 0;
                end else if (rose) begin
                    m_ph[d][c] = 1; m_rc[d][c] = 0;
                end else if (tk_old && m_ph[d][c] != 0) begin
                    if (!en_repeat[c]) begin
                        m_ph[d][c] = 1; m_rc[d][c] = 0;
                    end else begin
                        m_rc[d][c]++;
                        if (m_rc[d][c] == ((m_ph[d][c] == 1) ? RD : RP)) begin
                            fire = 1'b1; m_ph[d][c] = 2; m_rc[d][c] = 0;
                        end
                    end
                end
                e.lvl[c] = m_lvl[d][c];
                e.pr[c]  = rose | fire;
                e.rl[c]  = fell;
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t ea, eb;
        model_step(0, 1, 1'b0, ea);
        q_a.push_back(ea);
        model_step(1, 4, 1'b1, eb);
        q_b.push_back(eb);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        exp_t e, g;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            g = {lvl_a, pr_a, rl_a, tk_a};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL scb_a t=%0t got lvl=%b pr=%b rl=%b tk=%b exp lvl=%b pr=%b rl=%b tk=%b",
                         $time, g.lvl, g.pr, g.rl, g.tk, e.lvl, e.pr, e.rl, e.tk);
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            g = {lvl_b, pr_b, rl_b, tk_b};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL scb_b t=%0t got lvl=%b pr=%b rl=%b tk=%b exp lvl=%b pr=%b rl=%b tk=%b",
                         $time, g.lvl, g.pr, g.rl, g.tk, e.lvl, e.pr, e.rl, e.tk);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    // Edges after the current one until press_pulse_a[c]; -1 if none.
    task automatic wait_press(input int c, input int lim, output int lat);
        lat = -1;
        for (int i = 1; i <= lim; i++) begin
            step1();
            if (pr_a[c]) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, rlat, npress, nrel, bad, ntk_a, ntk_b, badgap, last;
        int pts[$];
        int hold[CH];

        rst = 1'b1; in = '0; en_repeat = '0;
        repeat (3) step1();
        rst = 1'b0;
        // still within the cycle after the last reset edge
        chk("reset_state_a", int'({lvl_a, pr_a, rl_a, tk_a}), 0);
        chk("reset_state_b", int'({lvl_b, pr_b, rl_b, tk_b}), 0);
        repeat (10) step1();

        // clean step on channel 0
        in[0] = 1'b1;
        wait_press(0, 20, lat);
        chk("step_latency", lat, 6);
        chk("step_isolated", int'(lvl_a[CH-1:1]), 0);
        repeat (3) step1();

        // bounce on channel 1, then settle high
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in[1] = ~in[1];
            repeat (2) begin
                step1();
                if (lvl_a[1] || pr_a[1]) bad++;
            end
        end
        chk("bounce_quiet", bad, 0);
        in[1] = 1'b1;
        wait_press(1, 20, lat);
        chk("bounce_settle_latency", lat, 6);

        // auto-repeat on channel 2
        en_repeat[2] = 1'b1;
        in[2] = 1'b1;
        pts.delete();
        for (int i = 1; i <= 30; i++) begin
            step1();
            if (pr_a[2]) pts.push_back(i);
        end
        while (pts.size() < 4) pts.push_back(-1000);
        chk("rep_first", pts[0], 6);
        chk("rep_delay", pts[1] - pts[0], 10);
        chk("rep_period1", pts[2] - pts[0], 13);
        chk("rep_period2", pts[3] - pts[0], 16);

        // release: one release pulse 6 edges later, no press afterwards
        in[2] = 1'b0;
        rlat = -1; nrel = 0; npress = 0;
        for (int i = 1; i <= 25; i++) begin
            step1();
            if (rl_a[2]) begin
                nrel++;
                if (rlat < 0) rlat = i;
            end
            if (pr_a[2] && rlat >= 0) npress++;
        end
        chk("rel_latency", rlat, 6);
        chk("rel_count", nrel, 1);
        chk("rel_no_press", npress, 0);

        // repeat disabled on channel 3, enabled mid-hold
        npress = 0;
        in[3] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step1();
            if (pr_a[3]) npress++;
        end
        chk("norep_count", npress, 1);
        en_repeat[3] = 1'b1;
        wait_press(3, 30, lat);
        chk("late_enable_latency", lat, 10);

        // reset while channel 2 repeats
        in[2] = 1'b1;
        repeat (25) step1();
        rst = 1'b1;
        step1();
        chk("midrst_cycle", int'({lvl_a, pr_a, rl_a, tk_a}), 0);
        rst = 1'b0;
        wait_press(2, 20, lat);
        chk("midrst_repress", lat, 6);

        // prescaler strobes
        ntk_a = 0; ntk_b = 0; badgap = 0; last = -1;
        for (int i = 0; i < 40; i++) begin
            step1();
            if (tk_a) ntk_a++;
            if (tk_b) begin
                ntk_b++;
                if (last >= 0 && i - last != 4) badgap++;
                last = i;
            end
        end
        chk("tick_a_count", ntk_a, 40);
        chk("tick_b_count", ntk_b, 10);
        chk("tick_b_spacing", badgap, 0);

        // randomized traffic checked by the scoreboard
        for (int c = 0; c < CH; c++) hold[c] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    in[c] = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 80));
                end else begin
                    hold[c]--;
                end
                if ($urandom_range(0, 99) == 0) en_repeat[c] = ~en_repeat[c];
            end
            rst = ($urandom_range(0, 1499) == 0);
            step1();
        end
        rst = 1'b0;
        repeat (3) step1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
